// File: rtl/i2c_pkg.sv
// Shared I2C definitions: transfer sizing, serializer state encoding and the bus idle level.
package i2c_pkg;

  localparam int MAX_BYTES = 31;
  localparam int BYTE_W    = 8;
  localparam int DATA_W    = MAX_BYTES * BYTE_W;
  localparam int CNT_W     = 5;
  localparam int BIT_CNT_W = 3;

  // Released open-drain SDA reads back high; used by both serializer and deserializer.
  localparam logic SDA_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } i2c_state_e;

endpackage

// File: rtl/i2c_sda_sync.sv
// Single-flop SDA input synchronizer; 1 CLK latency, resets to the released bus level.
module i2c_sda_sync
  import i2c_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic sda_raw,
  output logic sda_sync
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sda_sync <= SDA_IDLE;
    end else begin
      sda_sync <= sda_raw;
    end
  end

endmodule

// File: rtl/i2c_serializer.sv
// I2C write-data serializer: up to 31 bytes MSB first on SDA, slave ACK sampled per byte; first bit 1 CLK after load.
// Paced entirely by SHIFT_OUT/ACK_SAMPLE under CLK_EN. I2C_SER_NACK_CONTINUE_EN: a NACK is flagged but the transfer continues.
module i2c_serializer
  import i2c_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLK_EN,
  input  logic [DATA_W-1:0] I2C_DATA_TX,
  input  logic [CNT_W-1:0]  NUM_BYTES,
  input  logic              LOAD_CORE_SIDE_REG,
  input  logic              SHIFT_OUT,
  input  logic              ACK_SAMPLE,
  input  logic              ABORT,
  input  logic              SDA_IN,
  output logic              SDA_OUT,
  output logic              TX_BUSY,
  output logic              BYTE_DONE,
  output logic              LAST_BYTE,
  output logic              TX_DONE,
  output logic              NACK_ERR
);

  i2c_state_e            state, state_d;
  logic [DATA_W-1:0]     tx_buf, tx_buf_d;
  logic [BYTE_W-1:0]     shreg, shreg_d;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [CNT_W-1:0]      bytes_left, bytes_left_d;
  logic                  sda_out_q, sda_out_d;
  logic                  byte_done_q, byte_done_d;
  logic                  tx_done_q, tx_done_d;
  logic                  nack_err_q, nack_err_d;
  logic                  sda_int;
  logic                  nack;
  logic                  advance;

  i2c_sda_sync u_sda_sync (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .sda_raw  (SDA_IN),
    .sda_sync (sda_int)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      tx_buf      <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      bytes_left  <= '0;
      sda_out_q   <= SDA_IDLE;
      byte_done_q <= 1'b0;
      tx_done_q   <= 1'b0;
      nack_err_q  <= 1'b0;
    end else begin
      state       <= state_d;
      tx_buf      <= tx_buf_d;
      shreg       <= shreg_d;
      bit_cnt     <= bit_cnt_d;
      bytes_left  <= bytes_left_d;
      sda_out_q   <= sda_out_d;
      byte_done_q <= byte_done_d;
      tx_done_q   <= tx_done_d;
      nack_err_q  <= nack_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    tx_buf_d     = tx_buf;
    shreg_d      = shreg;
    bit_cnt_d    = bit_cnt;
    bytes_left_d = bytes_left;
    sda_out_d    = sda_out_q;
    byte_done_d  = 1'b0;
    tx_done_d    = 1'b0;
    nack_err_d   = nack_err_q;
    nack         = sda_int;
`ifdef I2C_SER_NACK_CONTINUE_EN
    advance      = 1'b1;
`else
    advance      = ~sda_int;
`endif

    // ABORT bypasses CLK_EN so the master can drop the bus at any instant.
    if (ABORT) begin
      state_d   = IDLE;
      sda_out_d = SDA_IDLE;
    end else if (CLK_EN) begin
      unique case (state)
        IDLE: begin
          if (LOAD_CORE_SIDE_REG && (NUM_BYTES != '0)) begin
            tx_buf_d     = I2C_DATA_TX;
            shreg_d      = I2C_DATA_TX[BYTE_W-1:0];
            sda_out_d    = I2C_DATA_TX[BYTE_W-1];
            bit_cnt_d    = BIT_CNT_W'(BYTE_W - 1);
            bytes_left_d = NUM_BYTES;
            nack_err_d   = 1'b0;
            state_d      = SHIFT;
          end
        end
        SHIFT: begin
          if (SHIFT_OUT) begin
            if (bit_cnt != '0) begin
              shreg_d   = {shreg[BYTE_W-2:0], 1'b0};
              sda_out_d = shreg[BYTE_W-2];
              bit_cnt_d = bit_cnt - 1'b1;
            end else begin
              sda_out_d   = SDA_IDLE;
              byte_done_d = 1'b1;
              state_d     = ACK;
            end
          end
        end
        ACK: begin
          if (ACK_SAMPLE) begin
            if (nack) begin
              nack_err_d = 1'b1;
            end
            if (!advance) begin
              state_d = IDLE;
            end else if (bytes_left == CNT_W'(1)) begin
              tx_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              // Byte 0 of tx_buf always mirrors the byte now in flight.
              tx_buf_d     = tx_buf >> BYTE_W;
              shreg_d      = tx_buf[2*BYTE_W-1:BYTE_W];
              sda_out_d    = tx_buf[2*BYTE_W-1];
              bytes_left_d = bytes_left - 1'b1;
              bit_cnt_d    = BIT_CNT_W'(BYTE_W - 1);
              state_d      = SHIFT;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          sda_out_d = SDA_IDLE;
        end
      endcase
    end
  end

  assign SDA_OUT   = sda_out_q;
  assign TX_BUSY   = (state != IDLE);
  assign BYTE_DONE = byte_done_q;
  assign LAST_BYTE = (bytes_left == CNT_W'(1)) && TX_BUSY;
  assign TX_DONE   = tx_done_q;
  assign NACK_ERR  = nack_err_q;

endmodule
